spi_slave_char_fifo: RTL and testbench

- Sits directly downstream of spi_slave_trx_char, on the same S_SYSCLK.
- Consumes each completed character (S_CHAR_DONE / S_RCHAR) into an RX FIFO. Tags the last character of a chip-select frame.
- Sources the next outgoing character on S_WCHAR from a TX FIFO.
- Host side is valid/ready streaming plus sticky status, so a bench or CPU wrapper can drive and check whole SPI frames.

---
 rtl/spi_slave_char_fifo_pkg.sv | 8 +
 rtl/spi_sync_fifo.sv | 39 +++
 rtl/spi_slave_char_fifo.sv | 93 +++++++++
 tb/tb_spi_slave_char_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_char_fifo_pkg.sv
// spi_slave_char_fifo_pkg: shared constants for the SPI character FIFO slice
package spi_slave_char_fifo_pkg;
  localparam int NBITS_CHAR_LEN_MAX = 32;
  localparam logic [NBITS_CHAR_LEN_MAX-1:0] TX_IDLE_DEFAULT = 32'hFFFF_FFFF;
  function automatic int rx_last_bit(input int char_nbits);
    return char_nbits;
  endfunction
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: synchronous first-word-fall-through FIFO with flush
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   full,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign count = wp - rp;
  assign wr = wr_en & ~full;
  assign rd = rd_en & ~empty;
  assign rd_data = mem[rp[AW-1:0]];
  // storage array, written only on accepted pushes
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= wr_data;
  // pointers wrap naturally; the extra MSB separates full from empty
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(wr);
      rp <= rp + (AW+1)'(rd);
    end
endmodule

// File: rtl/spi_slave_char_fifo.sv
// spi_slave_char_fifo: RX/TX character FIFOs with frame tagging behind spi_slave_trx_char
module spi_slave_char_fifo
  import spi_slave_char_fifo_pkg::*;
#(
  parameter int CHAR_NBITS = 32,
  parameter int DEPTH = 8,
  parameter logic [NBITS_CHAR_LEN_MAX-1:0] TX_IDLE = TX_IDLE_DEFAULT
) (
  input  logic                   S_SYSCLK,
  input  logic                   S_RESET,
  input  logic                   S_ENABLE,
  input  logic                   S_SPI_CS,
  input  logic                   S_CHAR_DONE,
  input  logic [CHAR_NBITS-1:0]  S_RCHAR,
  output logic [CHAR_NBITS-1:0]  S_WCHAR,
  output logic [CHAR_NBITS-1:0]  M_RX_DATA,
  output logic                   M_RX_LAST,
  output logic                   M_RX_VALID,
  input  logic                   M_RX_READY,
  input  logic [CHAR_NBITS-1:0]  S_TX_DATA,
  input  logic                   S_TX_VALID,
  output logic                   S_TX_READY,
  output logic [$clog2(DEPTH):0] RX_COUNT,
  output logic [$clog2(DEPTH):0] TX_COUNT,
  output logic                   RX_OVF,
  output logic                   TX_UDF,
  input  logic                   S_CLR_FLAGS
);
  localparam int AW = $clog2(DEPTH);
  localparam int LB = rx_last_bit(CHAR_NBITS);
  localparam logic [CHAR_NBITS-1:0] IDLE = TX_IDLE[CHAR_NBITS-1:0];
  logic cs_s1, cs_s2, cs_s3, done_q, stage_v, pend;
  logic frame_start, frame_end, done_ev, end_ev, tx_ev, rx_push, rx_full, rx_empty, tx_full, tx_empty;
  logic [CHAR_NBITS-1:0] stage_d, tx_head;
  logic [CHAR_NBITS:0] rx_head, rx_wdata;
  logic [AW:0] rx_fcount;
  assign frame_start = S_ENABLE & cs_s3 & ~cs_s2;
  assign frame_end = S_ENABLE & ~cs_s3 & cs_s2;
  assign done_ev = S_ENABLE & S_CHAR_DONE & ~done_q;
  assign end_ev = S_ENABLE & (frame_end | pend);
  assign tx_ev = frame_start | done_ev;
  assign rx_push = stage_v & (done_ev | end_ev);
  assign M_RX_VALID = ~rx_empty & ~S_RESET;
  assign M_RX_DATA = rx_head[CHAR_NBITS-1:0];
  assign M_RX_LAST = rx_head[LB];
  assign S_TX_READY = ~tx_full & S_ENABLE & ~S_RESET;
  assign RX_COUNT = rx_fcount + {{AW{1'b0}}, stage_v};
  // a char_done push is never the frame's last; a frame-end push always is
  always_comb begin
    rx_wdata = {1'b0, stage_d};
    rx_wdata[LB] = ~done_ev;
  end
  spi_sync_fifo #(.WIDTH(CHAR_NBITS+1), .DEPTH(DEPTH)) u_rx (
    .clk(S_SYSCLK), .rst(S_RESET), .flush(~S_ENABLE),
    .wr_en(rx_push), .wr_data(rx_wdata), .full(rx_full),
    .rd_en(M_RX_VALID & M_RX_READY), .rd_data(rx_head), .empty(rx_empty), .count(rx_fcount)
  );
  spi_sync_fifo #(.WIDTH(CHAR_NBITS), .DEPTH(DEPTH)) u_tx (
    .clk(S_SYSCLK), .rst(S_RESET), .flush(~S_ENABLE),
    .wr_en(S_TX_VALID & S_TX_READY), .wr_data(S_TX_DATA), .full(tx_full),
    .rd_en(tx_ev), .rd_data(tx_head), .empty(tx_empty), .count(TX_COUNT)
  );
  // two-flop CS synchronizer plus edge history, and char_done history
  always_ff @(posedge S_SYSCLK)
    if (S_RESET) {cs_s1, cs_s2, cs_s3, done_q} <= 4'b1110;
    else {cs_s1, cs_s2, cs_s3, done_q} <= {S_SPI_CS, cs_s1, cs_s2, S_CHAR_DONE};
  // stage occupancy; a frame end colliding with char_done is deferred one cycle
  always_ff @(posedge S_SYSCLK)
    if (S_RESET || !S_ENABLE) begin
      stage_v <= 1'b0;
      pend <= 1'b0;
    end else if (done_ev) begin
      stage_v <= 1'b1;
      pend <= end_ev;
    end else if (end_ev) begin
      stage_v <= 1'b0;
      pend <= 1'b0;
    end
  // staged character data
  always_ff @(posedge S_SYSCLK)
    if (done_ev) stage_d <= S_RCHAR;
  // outgoing character register and sticky flags, where a set beats a clear
  always_ff @(posedge S_SYSCLK)
    if (S_RESET) begin
      S_WCHAR <= IDLE;
      RX_OVF <= 1'b0;
      TX_UDF <= 1'b0;
    end else begin
      S_WCHAR <= !S_ENABLE ? IDLE : !tx_ev ? S_WCHAR : tx_empty ? IDLE : tx_head;
      RX_OVF <= (rx_push & rx_full) | (RX_OVF & ~S_CLR_FLAGS);
      TX_UDF <= (tx_ev & tx_empty) | (TX_UDF & ~S_CLR_FLAGS);
    end
endmodule

// File: tb/tb_spi_slave_char_fifo.sv
// tb_spi_slave_char_fifo: scoreboard and vector bench for spi_slave_char_fifo
module tb_spi_slave_char_fifo;
  logic clk = 1'b0;
  logic rst, en, cs, done, rx_ready, tx_valid, clr;
  logic [31:0] rchar, tx_data, wchar, rx_data;
  logic rx_last, rx_valid, tx_ready, rx_ovf, tx_udf;
  logic [3:0] rx_count, tx_count;
  int n_vec = 0;
  int n_err = 0;
  typedef struct { logic [31:0] d; logic last; } exp_t;
  typedef struct { logic [31:0] d; logic end_frame; logic last; } vec_t;
  exp_t exp_q[$];
  vec_t vt[4];
  always #5 clk = ~clk;
  spi_slave_char_fifo dut (
    .S_SYSCLK(clk), .S_RESET(rst), .S_ENABLE(en), .S_SPI_CS(cs),
    .S_CHAR_DONE(done), .S_RCHAR(rchar), .S_WCHAR(wchar),
    .M_RX_DATA(rx_data), .M_RX_LAST(rx_last), .M_RX_VALID(rx_valid), .M_RX_READY(rx_ready),
    .S_TX_DATA(tx_data), .S_TX_VALID(tx_valid), .S_TX_READY(tx_ready),
    .RX_COUNT(rx_count), .TX_COUNT(tx_count), .RX_OVF(rx_ovf), .TX_UDF(tx_udf),
    .S_CLR_FLAGS(clr)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cs_set(input logic v);
    cs = v;
    repeat (3) tick();
  endtask
  task automatic send_char(input logic [31:0] d);
    rchar = d;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask
  task automatic tx_push(input logic [31:0] d);
    tx_data = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask
  task automatic expect_rx(input logic [31:0] d, input logic last);
    exp_t e;
    e.d = d;
    e.last = last;
    exp_q.push_back(e);
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("rx_drain_left", 64'(exp_q.size()), 64'd0);
  endtask
  task automatic clear_flags();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask
  always @(negedge clk)
    if (rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check("rx_unexpected_pop", {31'd0, rx_last, rx_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_data", rx_data, e.d);
        check("rx_last", rx_last, e.last);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vt[0] = '{32'h1faa1234, 1'b0, 1'b0};
    vt[1] = '{32'h55aa0001, 1'b0, 1'b0};
    vt[2] = '{32'h12345678, 1'b1, 1'b1};
    vt[3] = '{32'hdeadbeef, 1'b1, 1'b1};
    rst = 1'b1; en = 1'b1; cs = 1'b1; done = 1'b0; rchar = '0;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_data = '0; clr = 1'b0;
    repeat (3) tick();
    check("tx_ready_in_reset", tx_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("reset_rx_count", rx_count, 0);
    check("reset_tx_count", tx_count, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_wchar", wchar, 32'hFFFF_FFFF);
    check("reset_flags", {rx_ovf, tx_udf}, 0);
    check("tx_ready_idle", tx_ready, 1'b1);
    // frame tagging from the vector table
    cs_set(1'b0);
    for (int i = 0; i < 4; i++) begin
      expect_rx(vt[i].d, vt[i].last);
      send_char(vt[i].d);
      if (vt[i].end_frame) begin
        cs_set(1'b1);
        if (i < 3) cs_set(1'b0);
      end
    end
    drain();
    check("udf_empty_tx", tx_udf, 1'b1);
    clear_flags();
    check("flags_cleared", {rx_ovf, tx_udf}, 0);
    // TX supply
    tx_push(32'h04030201);
    tx_push(32'h11223344);
    check("tx_count_2", tx_count, 2);
    cs_set(1'b0);
    check("wchar_frame_start", wchar, 32'h04030201);
    check("tx_count_1", tx_count, 1);
    expect_rx(32'hA0A0A0A0, 1'b0);
    send_char(32'hA0A0A0A0);
    check("wchar_event1", wchar, 32'h11223344);
    check("udf_not_yet", tx_udf, 1'b0);
    expect_rx(32'hB0B0B0B0, 1'b1);
    send_char(32'hB0B0B0B0);
    check("wchar_underflow", wchar, 32'hFFFF_FFFF);
    check("udf_set", tx_udf, 1'b1);
    cs_set(1'b1);
    drain();
    clear_flags();
    // overflow with consumer stalled
    rx_ready = 1'b0;
    cs_set(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) expect_rx(32'h100 + i, 1'b0);
      send_char(32'h100 + i);
      check("ovf_rx_count", rx_count, (i + 1 > 9) ? 9 : i + 1);
      if (i == 8) check("ovf_not_yet", rx_ovf, 1'b0);
    end
    check("ovf_set", rx_ovf, 1'b1);
    cs_set(1'b1);
    check("ovf_count_after_end", rx_count, 8);
    rx_ready = 1'b1;
    drain();
    check("ovf_sticky", rx_ovf, 1'b1);
    clear_flags();
    // char_done in the same cycle as the synced CS rise
    cs_set(1'b0);
    expect_rx(32'hC1C1C1C1, 1'b0);
    send_char(32'hC1C1C1C1);
    cs = 1'b1;
    tick();
    tick();
    rchar = 32'hC2C2C2C2;
    done = 1'b1;
    expect_rx(32'hC2C2C2C2, 1'b1);
    tick();
    done = 1'b0;
    tick();
    drain();
    check("same_cycle_no_ovf", rx_ovf, 1'b0);
    check("same_cycle_empty", rx_count, 0);
    // level-held char_done, then disable
    rx_ready = 1'b0;
    cs_set(1'b0);
    rchar = 32'hD0D0D0D0;
    done = 1'b1;
    repeat (5) tick();
    done = 1'b0;
    tick();
    check("held_done_count", rx_count, 1);
    cs_set(1'b1);
    check("held_done_fifo", {rx_valid, rx_last, rx_count}, {1'b1, 1'b1, 4'd1});
    check("held_done_data", rx_data, 32'hD0D0D0D0);
    cs_set(1'b0);
    for (int i = 0; i < 9; i++) send_char(32'h200 + i);
    check("fill_count", rx_count, 9);
    check("fill_ovf", rx_ovf, 1'b1);
    tx_push(32'h0BADF00D);
    check("fill_tx_count", tx_count, 1);
    en = 1'b0;
    tick();
    check("dis_rx_count", rx_count, 0);
    check("dis_tx_count", tx_count, 0);
    check("dis_rx_valid", rx_valid, 0);
    check("dis_wchar", wchar, 32'hFFFF_FFFF);
    check("dis_tx_ready", tx_ready, 0);
    send_char(32'h300);
    tx_push(32'h301);
    check("dis_ignored", {rx_count, tx_count}, 0);
    check("dis_ovf_held", rx_ovf, 1'b1);
    clear_flags();
    check("dis_ovf_cleared", rx_ovf, 1'b0);
    // reset mid-frame with entries queued
    en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_char(32'h400 + i);
    for (int i = 0; i < 3; i++) tx_push(32'h500 + i);
    check("pre_reset_counts", {rx_count, tx_count}, {4'd4, 4'd3});
    check("pre_reset_udf", tx_udf, 1'b1);
    rst = 1'b1;
    cs = 1'b1;
    tick();
    check("mid_reset_counts", {rx_count, tx_count}, 0);
    check("mid_reset_valid", rx_valid, 0);
    check("mid_reset_wchar", wchar, 32'hFFFF_FFFF);
    check("mid_reset_flags", {rx_ovf, tx_udf, tx_ready}, 0);
    rst = 1'b0;
    rx_ready = 1'b1;
    repeat (5) tick();
    check("post_reset_valid", rx_valid, 0);
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
